// File: rtl/icache_pkg.sv
// Shared FSM state type, line geometry and refill request encodings for the instruction cache.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL,
        S_UNCACHED
    } state_t;

    localparam int          OFFSET_W     = 4;
    localparam int          LINE_W       = 128;
    localparam logic [2:0]  RD_TYPE_WORD = 3'd2;
    localparam logic [2:0]  RD_TYPE_LINE = 3'd4;

    function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line, input logic [1:0] sel);
        return line[{sel, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data store: one synchronous write port, one combinational read port, bulk valid clear.
// Valid bits reset with rst; tag and data are left unreset.
module icache_array
    import icache_pkg::*;
#(
    parameter int NSETS = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [TAG_W-1:0]  i_wtag,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic              o_vld,
    output logic [TAG_W-1:0]  o_tag,
    output logic [LINE_W-1:0] o_data
);

    logic [NSETS-1:0]  r_vld;
    logic [TAG_W-1:0]  r_tag  [NSETS];
    logic [LINE_W-1:0] r_data [NSETS];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_vld <= '0;
        end else if (i_we) begin
            r_vld[i_widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_vld  = r_vld[i_ridx];
    assign o_tag  = r_tag[i_ridx];
    assign o_data = r_data[i_ridx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped I-cache, 16-byte lines, uncached word path below UNCACHED_LIMIT; ICACHE_PERF_EN adds hit/miss counters.
// Hit answers one cycle after accept; one fetch in flight (cpu_ready low while busy), refill request held until rd_ready.
module icache_dm
    import icache_pkg::*;
#(
    parameter int          NSETS          = 64,
    parameter logic [31:0] UNCACHED_LIMIT = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        fence_i,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [2:0]  rd_type,
    input  logic        rd_ready,
    input  logic [63:0] rdata,
    input  logic        rlast,
    input  logic        rvalid
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
`endif
);

    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = 32 - OFFSET_W - IDX_W;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [63:0] r_beat0;
    logic        r_fence_pend;
    logic        r_unc_sent;

    logic              w_arr_vld;
    logic [TAG_W-1:0]  w_arr_tag;
    logic [LINE_W-1:0] w_arr_data;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic              w_uncached;
    logic              w_we;
    logic              w_clr;

    assign w_idx      = r_addr[OFFSET_W +: IDX_W];
    assign w_tag      = r_addr[31 -: TAG_W];
    assign w_hit      = w_arr_vld && (w_arr_tag == w_tag);
    assign w_uncached = (r_addr < UNCACHED_LIMIT);

    icache_array #(
        .NSETS (NSETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_we    (w_we),
        .i_widx  (w_idx),
        .i_wtag  (w_tag),
        .i_wdata ({rdata, r_beat0}),
        .i_ridx  (w_idx),
        .o_vld   (w_arr_vld),
        .o_tag   (w_arr_tag),
        .o_data  (w_arr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        cpu_ready  = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        rd_type    = '0;
        w_we       = 1'b0;
        w_clr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fence_i || r_fence_pend) begin
                    w_clr = 1'b1;
                end else begin
                    cpu_ready = 1'b1;
                    if (cpu_req) w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_uncached) begin
                    w_next = S_UNCACHED;
                end else if (w_hit) begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = line_word(w_arr_data, r_addr[3:2]);
                    w_next     = S_IDLE;
                end else begin
                    w_next = S_MISS;
                end
            end
            S_MISS: begin
                rd_req  = 1'b1;
                rd_addr = {r_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                rd_type = RD_TYPE_LINE;
                if (rd_ready) w_next = S_REFILL;
            end
            S_REFILL: begin
                // Second beat carries bytes 15:8; commit the whole line and replay the lookup.
                if (rvalid && rlast) begin
                    w_we   = 1'b1;
                    w_next = S_LOOKUP;
                end
            end
            S_UNCACHED: begin
                if (!r_unc_sent) begin
                    rd_req  = 1'b1;
                    rd_addr = r_addr;
                    rd_type = RD_TYPE_WORD;
                end else if (rvalid && rlast) begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = r_addr[2] ? rdata[63:32] : rdata[31:0];
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            cpu_ready  = 1'b0;
            cpu_rvalid = 1'b0;
            cpu_rdata  = '0;
            rd_req     = 1'b0;
            rd_addr    = '0;
            rd_type    = '0;
            w_we       = 1'b0;
            w_clr      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fence_pend <= 1'b0;
            r_unc_sent   <= 1'b0;
        end else begin
            if (w_clr) begin
                r_fence_pend <= 1'b0;
            end else if (fence_i) begin
                r_fence_pend <= 1'b1;
            end
            r_unc_sent <= (r_state == S_UNCACHED) && (r_unc_sent || rd_ready)
                          && (w_next == S_UNCACHED);
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_req && cpu_ready) r_addr <= cpu_addr;
        if ((r_state == S_REFILL) && rvalid && !rlast) r_beat0 <= rdata;
    end

`ifdef ICACHE_PERF_EN
    logic        r_replay;
    logic [31:0] r_perf_hit;
    logic [31:0] r_perf_miss;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_replay    <= 1'b0;
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
        end else begin
            r_replay <= (r_state == S_REFILL) && (w_next == S_LOOKUP);
            if (r_state == S_LOOKUP) begin
                if (!w_uncached && w_hit && !r_replay) r_perf_hit <= r_perf_hit + 32'd1;
                if (w_uncached || !w_hit) r_perf_miss <= r_perf_miss + 32'd1;
            end
        end
    end

    assign perf_hit  = r_perf_hit;
    assign perf_miss = r_perf_miss;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized fetch traffic against a line-level cache model.
module tb_icache_dm;

    localparam int          NSETS = 64;
    localparam int          IDXW  = 6;
    localparam logic [31:0] LIMIT = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        fence_i;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [2:0]  rd_type;
    logic        rd_ready;
    logic [63:0] rdata;
    logic        rlast;
    logic        rvalid;

    icache_dm #(.NSETS(NSETS), .UNCACHED_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .fence_i    (fence_i),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_type    (rd_type),
        .rd_ready   (rd_ready),
        .rdata      (rdata),
        .rlast      (rlast),
        .rvalid     (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Model: per set, which line address (addr[31:4]) is resident, and its four words.
    bit          mvalid [NSETS];
    logic [27:0] mline  [NSETS];
    logic [31:0] mword  [NSETS][4];
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mem64(input logic [31:0] a);
        logic [31:0] x;
        x = a * 32'h9E37_79B9;
        return {x ^ 32'h5A5A_1234, a ^ 32'hC0DE_0000};
    endfunction

    task automatic model_flush();
        for (int i = 0; i < NSETS; i++) mvalid[i] = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  cpu_ready,  0);
        chk({tag, "_rvalid"}, cpu_rvalid, 0);
        chk({tag, "_rdata"},  cpu_rdata,  0);
        chk({tag, "_rdreq"},  rd_req,     0);
        chk({tag, "_rdaddr"}, rd_addr,    0);
        chk({tag, "_rdtype"}, rd_type,    0);
    endtask

    // Every response must be one the model predicted; held requests must stay stable.
    task automatic monitor();
        logic        prq;
        logic        prdy;
        logic [31:0] pad;
        logic [2:0]  pty;
        prq = 1'b0; prdy = 1'b0; pad = '0; pty = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cpu_rvalid) begin
                    if (exp_q.size() == 0) chk("spurious_rvalid", cpu_rvalid, 0);
                    else chk("rdata", cpu_rdata, exp_q.pop_front());
                end
                if (prq && !prdy) begin
                    chk("hold_rdreq",  rd_req,  1);
                    chk("hold_rdaddr", rd_addr, pad);
                    chk("hold_rdtype", rd_type, pty);
                end
            end
            prq = rd_req && !rst; prdy = rd_ready; pad = rd_addr; pty = rd_type;
        end
    endtask

    task automatic do_fence();
        fence_i = 1'b1;
        @(negedge clk);
        chk("fence_ready", cpu_ready, 0);
        step();
        fence_i = 1'b0;
        model_flush();
    endtask

    task automatic fetch(input logic [31:0] a, input logic [63:0] b0, input logic [63:0] b1,
                         input bit use_b, input int dly, input bit fence_mid, input bit rst_mid,
                         output logic [31:0] got);
        bit             unc;
        bit             hit;
        int             n;
        logic [IDXW-1:0] idx;
        logic [63:0]    beat0;
        logic [63:0]    beat1;
        got = '0;
        unc = (a < LIMIT);
        idx = a[4 +: IDXW];
        hit = !unc && mvalid[idx] && (mline[idx] == a[31:4]);

        cpu_req = 1'b1; cpu_addr = a;
        n = 0;
        @(negedge clk);
        while (!cpu_ready && n < 20) begin
            step(); @(negedge clk); n++;
        end
        if (!cpu_ready) begin
            chk("accept_timeout", cpu_ready, 1);
            cpu_req = 1'b0;
            return;
        end
        chk("idle_rdreq", rd_req, 0);
        step();
        cpu_req = 1'b0; cpu_addr = $urandom;
        if (hit) exp_q.push_back(mword[idx][a[3:2]]);
        @(negedge clk);
        chk("lookup_rvalid", cpu_rvalid, hit);
        chk("lookup_rdreq",  rd_req, 0);
        if (hit) begin
            got = cpu_rdata;
            step();
            return;
        end
        step();

        for (int k = 0; k <= dly; k++) begin
            rd_ready = (k == dly);
            rvalid   = (k < dly) && ($urandom_range(0, 1) == 1);
            rlast    = rvalid;
            rdata    = {$urandom, $urandom};
            @(negedge clk);
            if (k == 0) begin
                chk("req_rdreq",  rd_req, 1);
                chk("req_rdaddr", rd_addr, unc ? a : {a[31:4], 4'h0});
                chk("req_rdtype", rd_type, unc ? 3'd2 : 3'd4);
            end
            step();
        end
        rd_ready = 1'b0; rvalid = 1'b0; rlast = 1'b0;

        if (unc) begin
            beat0   = use_b ? b0 : mem64({a[31:3], 3'b0});
            rvalid  = ($urandom_range(0, 1) == 1);
            rlast   = 1'b0;
            rdata   = {$urandom, $urandom};
            fence_i = fence_mid;
            @(negedge clk);
            chk("unc_pre_rvalid", cpu_rvalid, 0);
            chk("unc_pre_rdreq",  rd_req, 0);
            step();
            fence_i = 1'b0;
            exp_q.push_back(a[2] ? beat0[63:32] : beat0[31:0]);
            rvalid = 1'b1; rlast = 1'b1; rdata = beat0;
            @(negedge clk);
            chk("unc_rvalid", cpu_rvalid, 1);
            got = cpu_rdata;
            step();
            rvalid = 1'b0; rlast = 1'b0;
        end else begin
            beat0 = use_b ? b0 : mem64({a[31:4], 4'h0});
            beat1 = use_b ? b1 : mem64({a[31:4], 4'h8});
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                step();
            end
            rvalid = 1'b1; rlast = 1'b0; rdata = beat0; fence_i = fence_mid;
            @(negedge clk);
            chk("refill_b0_rvalid", cpu_rvalid, 0);
            step();
            rvalid = 1'b0; fence_i = 1'b0;
            if (rst_mid) begin
                rst = 1'b1;
                @(negedge clk);
                chk_reset_outputs("midrst");
                step();
                rst = 1'b0;
                model_flush();
                exp_q.delete();
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                step();
            end
            rvalid = 1'b1; rlast = 1'b1; rdata = beat1;
            @(negedge clk);
            chk("refill_b1_rvalid", cpu_rvalid, 0);
            step();
            rvalid = 1'b0; rlast = 1'b0;
            mvalid[idx] = 1'b1;
            mline[idx]  = a[31:4];
            mword[idx][0] = beat0[31:0];
            mword[idx][1] = beat0[63:32];
            mword[idx][2] = beat1[31:0];
            mword[idx][3] = beat1[63:32];
            exp_q.push_back(mword[idx][a[3:2]]);
            @(negedge clk);
            chk("replay_rvalid", cpu_rvalid, 1);
            got = cpu_rdata;
            step();
        end
        if (fence_mid) model_flush();
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        int          r;
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; fence_i = 1'b0;
        rd_ready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
        checks = 0; errors = 0;
        model_flush();
        fork
            monitor();
            begin
                repeat (60000) @(posedge clk);
                $display("FAIL watchdog: simulation did not complete in budget");
                $fatal(1);
            end
        join_none

        repeat (3) step();
        cpu_req = 1'b1; cpu_addr = 32'h8000_0000;
        @(negedge clk);
        chk_reset_outputs("por");
        step();
        rst = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        chk("por_idle_ready", cpu_ready, 1);
        step();

        // Cold line fetch with rd_ready stalled five cycles, then a hit on the same line.
        fetch(32'h8000_0010, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1, 5, 0, 0, got);
        chk("cold_word", got, 32'h3333_4444);
        fetch(32'h8000_001C, 64'h0, 64'h0, 0, 0, 0, 0, got);
        chk("hit_word", got, 32'h5555_6666);

        // Uncached word, then the same address must go out again.
        fetch(32'h1000_0004, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 1, 1, 0, 0, got);
        chk("unc_word", got, 32'hAAAA_BBBB);
        fetch(32'h1000_0004, 64'h0, 64'h0, 0, 0, 0, 0, got);

        // Fence arriving mid-refill: word still returned, line gone afterwards.
        fetch(32'h8000_0020, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1, 0, 1, 0, got);
        chk("fence_mid_word", got, 32'h89AB_CDEF);
        fetch(32'h8000_0020, 64'h0, 64'h0, 0, 2, 0, 0, got);
        fetch(32'h8000_0028, 64'h0, 64'h0, 0, 0, 0, 0, got);

        // Fence in IDLE drops everything.
        fetch(32'h8000_0040, 64'h0, 64'h0, 0, 0, 0, 0, got);
        do_fence();
        fetch(32'h8000_0044, 64'h0, 64'h0, 0, 0, 0, 0, got);

        // Reset after the first refill beat abandons the line.
        fetch(32'h8000_0050, 64'h0, 64'h0, 0, 0, 0, 1, got);
        fetch(32'h8000_0050, 64'h0, 64'h0, 0, 0, 0, 0, got);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 99);
            if (r < 25) a = 32'h1000_0000 + (32'($urandom_range(0, 63)) << 2);
            else a = 32'h8000_0000 + (32'($urandom_range(0, 3)) << 10)
                   + (32'($urandom_range(0, 7)) << 4) + (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 99) < 5) do_fence();
            fetch(a, 64'h0, 64'h0, 0, $urandom_range(0, 3),
                  ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 3), got);
        end

        repeat (3) step();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
